// File: rtl/monstru_ctrl.sv
// monstru_ctrl: sequencer for the monstru 512-bit block assembler.
//
// Takes one message as a stream of 32-bit words. It drives monstru's store
// strobes and the pkt bus to build 16-word blocks:
//   1. the data words,
//   2. a single pad word,
//   3. zero fill,
//   4. the 64-bit message bit-length in slots 14 (high half) and 15 (low half).
//
// Each full block is presented downstream with blk_vld and held until blk_ack.
// Padding that does not fit beside the length words spills into one extra
// block.
//
// Ports:
//   clk, rst_b                 clock (rising edge), async active-low reset
//   start                      begin a new message (IDLE only)
//   w_vld, w_last, w_data      message word stream; w_rdy accepts it
//   ldx                        monstru write index (slot of the next write)
//   pkt                        word presented to monstru
//   st_pkt/pad_pkt/zero_pkt    store pkt / pad word / zero at ldx
//   hi_mgln/lo_mgln            store length[63:32] / length[31:0] at ldx
//   inc_mgln                   length += 32
//   c_up                       advance ldx
//   clr                        clear ldx, block and length
//   blk_vld, blk_last, blk_ack block handshake to downstream
//   busy                       sequencer not idle
//   blk_cnt                    blocks acknowledged for the current message
module monstru_ctrl #(
  parameter logic [31:0] PAD_WORD = 32'h8000_0000,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic             w_vld,
  input  logic             w_last,
  input  logic [31:0]      w_data,
  output logic             w_rdy,
  input  logic [3:0]       ldx,
  output logic [31:0]      pkt,
  output logic             st_pkt,
  output logic             pad_pkt,
  output logic             zero_pkt,
  output logic             hi_mgln,
  output logic             lo_mgln,
  output logic             inc_mgln,
  output logic             c_up,
  output logic             clr,
  output logic             blk_vld,
  output logic             blk_last,
  input  logic             blk_ack,
  output logic             busy,
  output logic [CNT_W-1:0] blk_cnt
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StPad,
    StZero,
    StHi,
    StLo,
    StEmit
  } state_e;

  state_e           state_q, state_d;
  // spill: zero fill runs to slot 15, and the length goes in a following block.
  logic             spill_q, spill_d;
  // pend_pad: message ended exactly at slot 15; the pad word opens the next block.
  logic             pend_pad_q, pend_pad_d;
  // spill_emit: the block in EMIT is a non-final spill block; resume with zero fill.
  logic             spill_emit_q, spill_emit_d;
  // last: the block in EMIT carries the length words.
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q      <= StIdle;
      spill_q      <= 1'b0;
      pend_pad_q   <= 1'b0;
      spill_emit_q <= 1'b0;
      last_q       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      spill_q      <= spill_d;
      pend_pad_q   <= pend_pad_d;
      spill_emit_q <= spill_emit_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    spill_d      = spill_q;
    pend_pad_d   = pend_pad_q;
    spill_emit_d = spill_emit_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    w_rdy        = 1'b0;
    pkt          = '0;
    st_pkt       = 1'b0;
    pad_pkt      = 1'b0;
    zero_pkt     = 1'b0;
    hi_mgln      = 1'b0;
    lo_mgln      = 1'b0;
    inc_mgln     = 1'b0;
    c_up         = 1'b0;
    clr          = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Gate with reset so every output is low while reset is held.
        if (start && rst_b) begin
          clr          = 1'b1;
          cnt_d        = '0;
          spill_d      = 1'b0;
          pend_pad_d   = 1'b0;
          spill_emit_d = 1'b0;
          last_d       = 1'b0;
          state_d      = StLoad;
        end
      end

      StLoad: begin
        w_rdy = 1'b1;
        if (w_vld) begin
          st_pkt   = 1'b1;
          inc_mgln = 1'b1;
          c_up     = 1'b1;
          pkt      = w_data;
          if (ldx == 4'd15) begin
            // Block is full either way; a final word here defers the pad.
            state_d    = StEmit;
            pend_pad_d = w_last;
          end else if (w_last) begin
            state_d = StPad;
          end
        end
      end

      StPad: begin
        pad_pkt = 1'b1;
        c_up    = 1'b1;
        pkt     = PAD_WORD;
        if (ldx == 4'd13) begin
          state_d = StHi;
        end else if (ldx == 4'd14) begin
          spill_d = 1'b1;
          state_d = StZero;
        end else if (ldx == 4'd15) begin
          spill_d      = 1'b0;
          spill_emit_d = 1'b1;
          state_d      = StEmit;
        end else begin
          state_d = StZero;
        end
      end

      StZero: begin
        zero_pkt = 1'b1;
        c_up     = 1'b1;
        if (spill_q && (ldx == 4'd15)) begin
          spill_d      = 1'b0;
          spill_emit_d = 1'b1;
          state_d      = StEmit;
        end else if (!spill_q && (ldx == 4'd13)) begin
          state_d = StHi;
        end
      end

      StHi: begin
        hi_mgln = 1'b1;
        c_up    = 1'b1;
        state_d = StLo;
      end

      StLo: begin
        lo_mgln = 1'b1;
        c_up    = 1'b1;
        last_d  = 1'b1;
        state_d = StEmit;
      end

      StEmit: begin
        if (blk_ack) begin
          if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
          end
          if (last_q) begin
            last_d  = 1'b0;
            state_d = StIdle;
          end else if (pend_pad_q) begin
            pend_pad_d = 1'b0;
            state_d    = StPad;
          end else if (spill_emit_q) begin
            spill_emit_d = 1'b0;
            state_d      = StZero;
          end else begin
            state_d = StLoad;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  assign blk_vld  = (state_q == StEmit);
  assign blk_last = blk_vld & last_q;
  assign busy     = (state_q != StIdle);
  assign blk_cnt  = cnt_q;

endmodule

// File: tb/tb_monstru_ctrl.sv
// Directed bench for monstru_ctrl.
//
// The bench includes a small model of the monstru assembler. The model holds
// the write index, the 16-word block and the bit-length, and it drives ldx
// back into the DUT. Expected block contents, strobe counts and latencies are
// literal constants worked out by hand for each message length.
module tb_monstru_ctrl;
  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_b;
  logic             start, w_vld, w_last, blk_ack;
  logic [31:0]      w_data;
  logic             w_rdy;
  logic [3:0]       ldx;
  logic [31:0]      pkt;
  logic             st_pkt, pad_pkt, zero_pkt, hi_mgln, lo_mgln, inc_mgln, c_up, clr;
  logic             blk_vld, blk_last, busy;
  logic [CNT_W-1:0] blk_cnt;

  monstru_ctrl #(
    .PAD_WORD (32'h8000_0000),
    .CNT_W    (CNT_W)
  ) u_dut (
    .clk      (clk),
    .rst_b    (rst_b),
    .start    (start),
    .w_vld    (w_vld),
    .w_last   (w_last),
    .w_data   (w_data),
    .w_rdy    (w_rdy),
    .ldx      (ldx),
    .pkt      (pkt),
    .st_pkt   (st_pkt),
    .pad_pkt  (pad_pkt),
    .zero_pkt (zero_pkt),
    .hi_mgln  (hi_mgln),
    .lo_mgln  (lo_mgln),
    .inc_mgln (inc_mgln),
    .c_up     (c_up),
    .clr      (clr),
    .blk_vld  (blk_vld),
    .blk_last (blk_last),
    .blk_ack  (blk_ack),
    .busy     (busy),
    .blk_cnt  (blk_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- monstru model ----------------
  logic [3:0]  m_ldx;
  logic [63:0] m_len;
  logic [31:0] mem [16];
  int          cyc = 0;
  int          n_st = 0, n_pad = 0, n_zero = 0, n_hi = 0, n_lo = 0;
  int          proto_bad = 0;
  int          last_pad = -1;

  assign ldx = m_ldx;

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      m_ldx <= '0;
      m_len <= '0;
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else if (clr) begin
      m_ldx <= '0;
      m_len <= '0;
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else begin
      if (st_pkt || pad_pkt || zero_pkt) mem[m_ldx] <= pkt;
      if (hi_mgln) mem[m_ldx] <= m_len[63:32];
      if (lo_mgln) mem[m_ldx] <= m_len[31:0];
      if (inc_mgln) m_len <= m_len + 64'd32;
      if (c_up) m_ldx <= m_ldx + 4'd1;
    end
  end

  always @(posedge clk) begin
    int ns;
    cyc <= cyc + 1;
    ns = int'(st_pkt) + int'(pad_pkt) + int'(zero_pkt) + int'(hi_mgln) + int'(lo_mgln);
    if (rst_b) begin
      if (ns > 1 || (ns == 1 && !c_up) || (ns == 0 && c_up)) proto_bad <= proto_bad + 1;
      if (st_pkt) n_st <= n_st + 1;
      if (pad_pkt) begin
        n_pad    <= n_pad + 1;
        last_pad <= int'(m_ldx);
      end
      if (zero_pkt) n_zero <= n_zero + 1;
      if (hi_mgln) n_hi <= n_hi + 1;
      if (lo_mgln) n_lo <= n_lo + 1;
    end
  end

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Observations from one run_msg call.
  int          lat, nblk, stall_bad, done;
  logic        lastv [2];
  logic [31:0] snap [2][16];
  int          st_c [2], pad_c [2], zero_c [2], hi_c [2], lo_c [2], pad_at [2];
  logic [CNT_W-1:0] cnt_after;
  logic        busy_after;

  // Sends an n-word message and acks each block after hold stall cycles.
  // The stall cycles are driven with start=1. w_vld stays high throughout.
  task automatic run_msg(input int n, input logic [31:0] d0, input int hold);
    int idx, guard, t0, b, xfer;
    int b_st, b_pad, b_zero, b_hi, b_lo;
    logic [CNT_W-1:0] cnt_hold;
    idx = 0; nblk = 0; stall_bad = 0; done = 0; lat = -1;
    for (int k = 0; k < 2; k++) begin
      lastv[k] = 1'bx; st_c[k] = -1; pad_c[k] = -1; zero_c[k] = -1;
      hi_c[k] = -1; lo_c[k] = -1; pad_at[k] = -1;
    end
    @(posedge clk); #1;
    start = 1'b1; w_vld = 1'b1; w_data = d0; w_last = (n == 1);
    @(negedge clk);
    chk("clr_on_start", clr, 1'b1);
    t0 = cyc;
    b_st = n_st; b_pad = n_pad; b_zero = n_zero; b_hi = n_hi; b_lo = n_lo;
    @(posedge clk); #1;
    start = 1'b0;
    guard = 0;
    while (done == 0 && guard < 200) begin
      @(negedge clk);
      guard++;
      xfer = int'(w_vld & w_rdy);
      if (blk_vld) begin
        b = nblk;
        if (b == 0) lat = cyc - t0;
        lastv[b]  = blk_last;
        for (int i = 0; i < 16; i++) snap[b][i] = mem[i];
        st_c[b]   = n_st - b_st;     b_st   = n_st;
        pad_c[b]  = n_pad - b_pad;   b_pad  = n_pad;
        zero_c[b] = n_zero - b_zero; b_zero = n_zero;
        hi_c[b]   = n_hi - b_hi;     b_hi   = n_hi;
        lo_c[b]   = n_lo - b_lo;     b_lo   = n_lo;
        pad_at[b] = last_pad;
        cnt_hold  = blk_cnt;
        for (int h = 0; h < hold; h++) begin
          @(posedge clk); #1;
          start = 1'b1;
          @(negedge clk);
          if (w_rdy || st_pkt || pad_pkt || zero_pkt || hi_mgln || lo_mgln || inc_mgln ||
              c_up || clr || !blk_vld || blk_last !== lastv[b] || blk_cnt !== cnt_hold)
            stall_bad++;
        end
        @(posedge clk); #1;
        start = 1'b0; blk_ack = 1'b1;
        @(posedge clk); #1;
        blk_ack = 1'b0;
        nblk++;
        if (lastv[b] === 1'b1 || nblk == 2) done = 1;
      end else begin
        @(posedge clk); #1;
        if (xfer != 0) begin
          idx++;
          if (idx < n) begin
            w_data = d0 + 32'(idx);
            w_last = (idx == n - 1);
          end else begin
            w_data = 32'hdead_beef;
            w_last = 1'b0;
          end
        end
      end
    end
    chk("run_finished", done, 1);
    @(negedge clk);
    cnt_after  = blk_cnt;
    busy_after = busy;
    w_vld = 1'b0; w_last = 1'b0;
  endtask

  function automatic logic [11:0] outs();
    return {w_rdy, st_pkt, pad_pkt, zero_pkt, hi_mgln, lo_mgln, inc_mgln, c_up, clr,
            blk_vld, blk_last, busy};
  endfunction

  initial begin
    int g;
    rst_b = 1'b0; start = 1'b0; w_vld = 1'b0; w_last = 1'b0; w_data = '0; blk_ack = 1'b0;
    #12;
    chk("rst_outs", outs(), 12'h000);
    chk("rst_pkt", pkt, 32'h0);
    chk("rst_cnt", blk_cnt, 8'd0);
    @(negedge clk);
    rst_b = 1'b1;

    // 1: single word
    run_msg(1, 32'h0123_4567, 0);
    chk("t1_lat", lat, 17);
    chk("t1_nblk", nblk, 1);
    chk("t1_last", lastv[0], 1'b1);
    chk("t1_w0", snap[0][0], 32'h0123_4567);
    chk("t1_pad", snap[0][1], 32'h8000_0000);
    chk("t1_z2", snap[0][2], 32'h0);
    chk("t1_z13", snap[0][13], 32'h0);
    chk("t1_hi", snap[0][14], 32'h0);
    chk("t1_lo", snap[0][15], 32'd32);
    chk("t1_nst", st_c[0], 1);
    chk("t1_npad", pad_c[0], 1);
    chk("t1_nzero", zero_c[0], 12);
    chk("t1_nhi", hi_c[0], 1);
    chk("t1_nlo", lo_c[0], 1);
    chk("t1_padx", pad_at[0], 1);
    chk("t1_cnt", cnt_after, 8'd1);
    chk("t1_busy", busy_after, 1'b0);

    // 2: 13 words, no zero fill
    run_msg(13, 32'h1000_0000, 0);
    chk("t2_lat", lat, 17);
    chk("t2_nblk", nblk, 1);
    chk("t2_last", lastv[0], 1'b1);
    chk("t2_w12", snap[0][12], 32'h1000_000c);
    chk("t2_pad", snap[0][13], 32'h8000_0000);
    chk("t2_lo", snap[0][15], 32'd416);
    chk("t2_nzero", zero_c[0], 0);
    chk("t2_padx", pad_at[0], 13);
    chk("t2_cnt", cnt_after, 8'd1);

    // 3: 14 words, pad at 14 spills
    run_msg(14, 32'h1000_0000, 0);
    chk("t3_nblk", nblk, 2);
    chk("t3_last0", lastv[0], 1'b0);
    chk("t3_padx", pad_at[0], 14);
    chk("t3_b0_13", snap[0][13], 32'h1000_000d);
    chk("t3_b0_14", snap[0][14], 32'h8000_0000);
    chk("t3_b0_15", snap[0][15], 32'h0);
    chk("t3_nzero0", zero_c[0], 1);
    chk("t3_last1", lastv[1], 1'b1);
    chk("t3_b1_0", snap[1][0], 32'h0);
    chk("t3_b1_15", snap[1][15], 32'd448);
    chk("t3_nzero1", zero_c[1], 14);
    chk("t3_nhi1", hi_c[1], 1);
    chk("t3_cnt", cnt_after, 8'd2);

    // 15 words: pad lands in slot 15
    run_msg(15, 32'h1000_0000, 0);
    chk("t15_last0", lastv[0], 1'b0);
    chk("t15_b0_15", snap[0][15], 32'h8000_0000);
    chk("t15_nzero1", zero_c[1], 14);
    chk("t15_b1_15", snap[1][15], 32'd480);
    chk("t15_cnt", cnt_after, 8'd2);

    // 4: 16 words, pad deferred to next block
    run_msg(16, 32'h1000_0000, 0);
    chk("t4_lat", lat, 17);
    chk("t4_last0", lastv[0], 1'b0);
    chk("t4_nst0", st_c[0], 16);
    chk("t4_npad0", pad_c[0], 0);
    chk("t4_b0_15", snap[0][15], 32'h1000_000f);
    chk("t4_padx1", pad_at[1], 0);
    chk("t4_b1_0", snap[1][0], 32'h8000_0000);
    chk("t4_b1_1", snap[1][1], 32'h0);
    chk("t4_nzero1", zero_c[1], 13);
    chk("t4_b1_15", snap[1][15], 32'd512);
    chk("t4_last1", lastv[1], 1'b1);
    chk("t4_cnt", cnt_after, 8'd2);

    // 5: same with 5 stall cycles per block
    run_msg(16, 32'h1000_0000, 5);
    chk("t5_stall", stall_bad, 0);
    chk("t5_b1_0", snap[1][0], 32'h8000_0000);
    chk("t5_nzero1", zero_c[1], 13);
    chk("t5_b1_15", snap[1][15], 32'd512);
    chk("t5_last1", lastv[1], 1'b1);
    chk("t5_cnt", cnt_after, 8'd2);

    // 6: reset mid-ZERO
    @(posedge clk); #1;
    start = 1'b1; w_vld = 1'b1; w_data = 32'h0bad_cafe; w_last = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    g = 0;
    while (!zero_pkt && g < 20) begin
      @(posedge clk); #1;
      w_last = 1'b0;
      g++;
    end
    chk("t6_in_zero", zero_pkt, 1'b1);
    @(posedge clk); #3;
    rst_b = 1'b0;
    #1;
    chk("t6_rst_outs", outs(), 12'h000);
    chk("t6_rst_pkt", pkt, 32'h0);
    chk("t6_rst_cnt", blk_cnt, 8'd0);
    w_vld = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    run_msg(1, 32'h0123_4567, 0);
    chk("t6_lat", lat, 17);
    chk("t6_last", lastv[0], 1'b1);
    chk("t6_lo", snap[0][15], 32'd32);
    chk("t6_nzero", zero_c[0], 12);
    chk("t6_cnt", cnt_after, 8'd1);

    chk("protocol", proto_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/monstru_ctrl.md
Name: monstru_ctrl

Overview:
Sequencer for the monstru 512-bit block assembler (16 x 32-bit words, write index ldx, message-length counter).
- Accepts a word stream for one message.
- Drives monstru's strobes and pkt bus to store data words, the pad word, zero fill and the 64-bit bit-length.
- Handles padding spill into an extra block.
- Hands each completed block downstream with a valid/ack handshake.

Parameters:
PAD_WORD, 32'h80000000, value driven on pkt during the pad_pkt cycle
CNT_W, 8, width of blk_cnt

Ports:
clk  in  1  clock, rising edge
rst_b  in  1  asynchronous active-low reset
start  in  1  begin new message; sampled only in IDLE
w_vld  in  1  message word valid
w_last  in  1  qualifies w_vld: final word of message
w_data  in  32  message word
w_rdy  out  1  word accepted when w_vld&w_rdy
ldx  in  4  monstru current write index (next word slot)
pkt  out  32  word to monstru
st_pkt  out  1  store pkt at ldx
pad_pkt  out  1  store pad word at ldx
zero_pkt  out  1  store zero at ldx
hi_mgln  out  1  store length[63:32] at ldx
lo_mgln  out  1  store length[31:0] at ldx
inc_mgln  out  1  length += 32
c_up  out  1  ldx += 1 (wraps 15->0)
clr  out  1  clear ldx, blk, length
blk_vld  out  1  blk holds a complete block
blk_last  out  1  with blk_vld: final block of message
blk_ack  in  1  downstream consumed block
busy  out  1  state != IDLE
blk_cnt  out  CNT_W  blocks acked for current message

Behaviour:
- Monstru contract: strobes take effect on the rising edge where they are high; ldx reflects the slot for the next write. Exactly one of st/pad/zero/hi/lo is high per write cycle, always with c_up=1.
- Reset (async, any state): state IDLE; all outputs 0; pkt=0; internal spill and pend_pad flags cleared; blk_cnt=0.
- All strobes, pkt and w_rdy are combinational from state/inputs. blk_vld, blk_last and busy are decoded from state.
- States: IDLE, LOAD, PAD, ZERO, HI, LO, EMIT.
- IDLE:
  - start=1 -> clr=1 for that cycle, blk_cnt<=0, next LOAD.
  - start is ignored in every other state.
- LOAD:
  - w_rdy=1.
  - On a transfer: st_pkt=inc_mgln=c_up=1, pkt=w_data.
  - After a transfer, next state is chosen by ldx at the write:
    - ldx=15 and !w_last -> EMIT (non-final).
    - ldx=15 and w_last -> EMIT, pend_pad<=1.
    - ldx<15 and w_last -> PAD.
    - Otherwise stay in LOAD.
- PAD:
  - pad_pkt=c_up=1, pkt=PAD_WORD.
  - Next state by ldx at the write:
    - ldx=13 -> HI.
    - ldx<13 -> ZERO.
    - ldx=14 -> ZERO, spill<=1.
    - ldx=15 -> EMIT, spill<=0.
- ZERO:
  - zero_pkt=c_up=1, pkt=0.
  - spill=1 and ldx=15 -> EMIT (non-final), spill<=0.
  - spill=0 and ldx=13 -> HI.
  - Otherwise stay in ZERO.
- HI: hi_mgln=c_up=1 (ldx=14), pkt=0, next LO.
- LO: lo_mgln=c_up=1 (ldx=15), pkt=0, next EMIT with blk_last=1.
- EMIT:
  - blk_vld=1; no strobes; w_rdy=0; monstru contents held.
  - On blk_ack: blk_cnt++ (saturating).
    - blk_last=1 -> IDLE.
    - pend_pad=1 -> PAD, pend_pad<=0.
    - Came from a non-final spill -> ZERO.
    - Otherwise -> LOAD.
  - blk_ack outside EMIT is ignored.
- blk_last is registered when entering EMIT from LO only.
- Single-block latency, N<=13 words, no stalls: blk_vld rises 17 cycles after the start cycle (1 clr + N store + 1 pad + (13-N) zero + hi + lo).
- A w_last seen with a word in LOAD is the only end-of-message event. An empty message is illegal; start is ignored until IDLE.

Test Plan:
1. start; 1 word 0x01234567 last, w_vld continuous -> strobes clr, st, pad, zero x12, hi, lo. blk_vld=1, blk_last=1 exactly 17 cycles after start. pkt=0x80000000 on pad cycle. blk_cnt=1 after ack.
2. 13 words -> pad at ldx 13, zero count 0, hi at 14, lo at 15. One block, blk_last=1.
3. 14 words -> pad at 14, zero at 15. EMIT blk_last=0; after ack, zero 0..13, hi, lo, EMIT blk_last=1. blk_cnt=2.
4. 16 words -> EMIT blk_last=0 after word at ldx 15; after ack, pad at ldx 0, zero 1..13, hi, lo, final EMIT. blk_cnt=2.
5. Hold blk_ack=0 for 5 cycles in EMIT, with w_vld=1 and start=1 -> w_rdy=0, no strobes, state unchanged. Ack -> resumes exactly as in 4.
6. Drop rst_b low mid-ZERO -> all outputs 0 immediately, busy=0. After release, a new start gives clr=1 and a normal run as in 1.
